hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator_pkg.sv | 17 +
 rtl/hvsync_generator.sv | 72 +++++++
 tb/tb_hvsync_generator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hvsync_generator_pkg.sv
// Shared counter type and small helpers for the raster timing generator.
package hvsync_generator_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Inclusive unsigned window test at counter width.
    function automatic logic in_window(cnt_t value, cnt_t lo, cnt_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

    function automatic cnt_t wrap_inc(cnt_t value, cnt_t max);
        return (value == max) ? '0 : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/hvsync_generator.sv
// VGA-style raster timing: free-running column/line counters, registered
// active-low syncs that lag the counters by one clock, combinational display_on.
module hvsync_generator
    import hvsync_generator_pkg::*;
#(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam cnt_t H_DISP_LIM   = cnt_t'(H_DISPLAY);
    localparam cnt_t H_MAX        = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t H_SYNC_START = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam cnt_t V_DISP_LIM   = cnt_t'(V_DISPLAY);
    localparam cnt_t V_MAX        = cnt_t'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam cnt_t V_SYNC_START = cnt_t'(V_DISPLAY + V_BOTTOM);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    cnt_t hpos_q, hpos_d;
    cnt_t vpos_q, vpos_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic line_end;

    always_comb begin
        line_end = (hpos_q == H_MAX);
        hpos_d   = wrap_inc(hpos_q, H_MAX);
        vpos_d   = vpos_q;
        if (line_end) begin
            vpos_d = wrap_inc(vpos_q, V_MAX);
        end
        // Syncs look at the pre-edge counters, hence the one-clock lag.
        hsync_d = ~in_window(hpos_q, H_SYNC_START, H_SYNC_END);
        vsync_d = ~in_window(vpos_q, V_SYNC_START, V_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_DISP_LIM) && (vpos_q < V_DISP_LIM);

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: default line timing with a shortened frame height
// so whole frames fit in a short run; outputs compared every cycle to a model.
module tb_hvsync_generator;

    localparam int HD  = 640;
    localparam int HF  = 16;
    localparam int HS  = 96;
    localparam int HB  = 48;
    localparam int VD  = 48;
    localparam int VB  = 10;
    localparam int VS  = 2;
    localparam int VTP = 3;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VB + VS + VTP;
    localparam int HSS = HD + HF;
    localparam int HSE = HSS + HS - 1;
    localparam int VSS = VD + VB;
    localparam int VSE = VSS + VS - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;

    int total = 0;
    int bad = 0;
    int n = 0;      // clocks since last reset edge
    bit seen = 1'b0;

    hvsync_generator #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VTP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsync     (hsync),
        .vsync     (vsync),
        .display_on(display_on),
        .hpos      (hpos),
        .vpos      (vpos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            n    <= 0;
            seen <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    function automatic int eh(int k);
        return k % HT;
    endfunction

    function automatic int ev(int k);
        return (k / HT) % VT;
    endfunction

    function automatic int ehs(int k);
        if (k == 0) return 1;
        return (eh(k - 1) >= HSS && eh(k - 1) <= HSE) ? 0 : 1;
    endfunction

    function automatic int evs(int k);
        if (k == 0) return 1;
        return (ev(k - 1) >= VSS && ev(k - 1) <= VSE) ? 0 : 1;
    endfunction

    function automatic int edisp(int k);
        return (eh(k) < HD && ev(k) < VD) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (seen) begin
            check("hpos", 32'(hpos), 32'(eh(n)));
            check("vpos", 32'(vpos), 32'(ev(n)));
            check("hsync", 32'(hsync), 32'(ehs(n)));
            check("vsync", 32'(vsync), 32'(evs(n)));
            check("display_on", 32'(display_on), 32'(edisp(n)));
        end
    end

    initial begin
        int hcnt, hfirst, vcnt, vfirst, maxv, waited;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hpos", 32'(hpos), 0);
        check("rst_vpos", 32'(vpos), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_display_on", 32'(display_on), 1);

        rst_n = 1'b1;
        hcnt = 0; hfirst = -1; vcnt = 0; vfirst = -1; maxv = 0;
        for (int k = 1; k <= HT * VT + 5; k++) begin
            @(negedge clk);
            if (k == 1) check("first_hpos", 32'(hpos), 1);
            if (k <= HT && hsync == 1'b0) begin
                hcnt++;
                if (hfirst < 0) hfirst = k;
            end
            if (k <= HT * VT && vsync == 1'b0) begin
                vcnt++;
                if (vfirst < 0) vfirst = k;
            end
            if (int'(vpos) > maxv) maxv = int'(vpos);
            if (k == 639) check("disp_at_639", 32'(display_on), 1);
            if (k == 640) check("disp_at_640", 32'(display_on), 0);
            if (k == 800) begin
                check("line_hpos", 32'(hpos), 0);
                check("line_vpos", 32'(vpos), 1);
            end
            if (k == HT * VT) begin
                check("frame_hpos", 32'(hpos), 0);
                check("frame_vpos", 32'(vpos), 0);
            end
        end
        check("hsync_low_clocks", 32'(hcnt), 96);
        check("hsync_first_low", 32'(hfirst), 657);
        check("vsync_low_clocks", 32'(vcnt), 1600);
        check("vsync_first_low", 32'(vfirst), 58 * 800 + 1);
        check("vpos_max", 32'(maxv), 62);

        // Mid-frame reset at hpos=300, vpos=5.
        waited = 0;
        while (!(eh(n) == 300 && ev(n) == 5) && waited < HT * VT + 10) begin
            @(negedge clk);
            waited++;
        end
        check("midreset_reached", 32'(waited < HT * VT + 10), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_hpos", 32'(hpos), 0);
        check("midreset_vpos", 32'(vpos), 0);
        check("midreset_hsync", 32'(hsync), 1);
        check("midreset_vsync", 32'(vsync), 1);
        check("midreset_display_on", 32'(display_on), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (900) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
